// File: rtl/fpu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_arbiter
// Brief    : Round-robin issue of two requesters onto one shared FP ALU,
//            with a tag pipeline and a credit-checked, id-tagged result FIFO.
// Revision : 1.0
// ============================================================================
module fpu_arbiter #(
    parameter int ALU_LAT     = 2,
    parameter int RFIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [1:0]  alu_op,
    input  logic [31:0] alu_o,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_data,
    output logic        busy
);
    localparam int c_PTR_W = (RFIFO_DEPTH > 1) ? $clog2(RFIFO_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(RFIFO_DEPTH + ALU_LAT + 1);

    logic [ALU_LAT-1:0]  r_tagValid;
    logic [ALU_LAT-1:0]  r_tagId;
    logic [31:0]         r_fifoData [RFIFO_DEPTH];
    logic                r_fifoId   [RFIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wrPtr;
    logic [c_PTR_W-1:0]  r_rdPtr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_lastGrant;

    logic [c_CNT_W-1:0]  w_tagCnt;
    logic [c_CNT_W-1:0]  w_outstanding;
    logic                w_issueOk;
    logic                w_grant0;
    logic                w_grant1;
    logic                w_push;
    logic                w_pop;

    always_comb begin
        w_tagCnt = '0;
        for (int i = 0; i < ALU_LAT; i++) begin
            w_tagCnt = w_tagCnt + c_CNT_W'(r_tagValid[i]);
        end
    end

    // Ops still in the ALU already own a FIFO slot, so the credit covers both.
    assign w_outstanding = w_tagCnt + r_count;
    assign w_issueOk     = w_outstanding < c_CNT_W'(RFIFO_DEPTH);

    assign w_grant0   = req0_valid & (~req1_valid | r_lastGrant);
    assign w_grant1   = req1_valid & (~req0_valid | ~r_lastGrant);
    assign req0_ready = rst_n & w_issueOk & w_grant0;
    assign req1_ready = rst_n & w_issueOk & w_grant1;

    assign w_push     = r_tagValid[ALU_LAT-1];
    assign w_pop      = resp_valid & resp_ready;

    assign resp_valid = (r_count != '0);
    assign resp_data  = r_fifoData[r_rdPtr];
    assign resp_id    = r_fifoId[r_rdPtr];
    assign busy       = (w_outstanding != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= 2'b00;
            r_tagValid  <= '0;
            r_tagId     <= '0;
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_lastGrant <= 1'b1;
        end else begin
            if (req0_ready) begin
                alu_a       <= req0_a;
                alu_b       <= req0_b;
                alu_op      <= req0_op;
                r_lastGrant <= 1'b0;
            end else if (req1_ready) begin
                alu_a       <= req1_a;
                alu_b       <= req1_b;
                alu_op      <= req1_op;
                r_lastGrant <= 1'b1;
            end
            r_tagValid[0] <= req0_ready | req1_ready;
            r_tagId[0]    <= req1_ready;
            for (int i = 1; i < ALU_LAT; i++) begin
                r_tagValid[i] <= r_tagValid[i-1];
                r_tagId[i]    <= r_tagId[i-1];
            end
            if (w_push) begin
                r_wrPtr <= (r_wrPtr == c_PTR_W'(RFIFO_DEPTH - 1)) ? '0 : r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= (r_rdPtr == c_PTR_W'(RFIFO_DEPTH - 1)) ? '0 : r_rdPtr + 1'b1;
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoData[r_wrPtr] <= alu_o;
            r_fifoId[r_wrPtr]   <= r_tagId[ALU_LAT-1];
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fpu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_arbiter
// Brief    : Directed stimulus with a queue scoreboard for fpu_arbiter.
// Revision : 1.0
// ============================================================================
module tb_fpu_arbiter;
    localparam int ALU_LAT     = 2;
    localparam int RFIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]  req0_op, req1_op, alu_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_o = '0;
    logic        resp_valid, resp_ready, resp_id;
    logic [31:0] resp_data;
    logic        busy;

    logic [31:0] exp0, exp1;
    logic        latChk;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic [31:0] cyc;
        logic        chkLat;
    } exp_t;
    exp_t sb[$];
    exp_t rmE;

    logic [1:0]  vOp  [8];
    logic [31:0] vA   [8];
    logic [31:0] vB   [8];
    logic [31:0] vExp [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fpu_arbiter #(.ALU_LAT(ALU_LAT), .RFIFO_DEPTH(RFIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_o(alu_o),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .busy(busy)
    );

    function automatic real toReal(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) return 0.0;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] toSingle(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fpModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00:   return toSingle(toReal(a) + toReal(b));
            2'b01:   return toSingle(toReal(a) - toReal(b));
            2'b10:   return (b[30:0] == 31'd0) ? 32'd0 : toSingle(toReal(a) / toReal(b));
            default: return toSingle(toReal(a) * toReal(b));
        endcase
    endfunction

    // ALU stand-in: one register stage plus the operand register gives two edges.
    always @(posedge clk) alu_o <= fpModel(alu_op, alu_a, alu_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive0(input logic v, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b; exp0 = e;
    endtask

    task automatic drive1(input logic v, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b; exp1 = e;
    endtask

    task automatic drain(input string name);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    // Issue side: every accepted request pushes its expected response.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req0_valid && req0_ready) sb.push_back('{1'b0, exp0, 32'(cyc), latChk});
            if (req1_valid && req1_ready) sb.push_back('{1'b1, exp1, 32'(cyc), latChk});
            check("ready_exclusive",
                  32'((req0_ready & req1_ready) | (req0_ready & ~req0_valid) | (req1_ready & ~req1_valid)),
                  32'd0);
        end
    end

    // Response side: every pop is compared against the oldest expectation.
    always @(negedge clk) begin
        if (resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual id=%0d data=%h required none", resp_id, resp_data);
            end else begin
                rmE = sb.pop_front();
                check("resp_id", 32'(resp_id), 32'(rmE.id));
                check("resp_data", resp_data, rmE.data);
                if (rmE.chkLat) check("resp_latency", 32'(cyc) - rmE.cyc, 32'(ALU_LAT + 1));
            end
        end
    end

    initial begin
        vOp[0] = 2'b00; vA[0] = 32'h3F800000; vB[0] = 32'h40000000; vExp[0] = 32'h40400000;
        vOp[1] = 2'b01; vA[1] = 32'h40A00000; vB[1] = 32'h3F800000; vExp[1] = 32'h40800000;
        vOp[2] = 2'b11; vA[2] = 32'h40000000; vB[2] = 32'h40400000; vExp[2] = 32'h40C00000;
        vOp[3] = 2'b10; vA[3] = 32'h40800000; vB[3] = 32'h40000000; vExp[3] = 32'h40000000;
        vOp[4] = 2'b10; vA[4] = 32'h40400000; vB[4] = 32'h40000000; vExp[4] = 32'h3FC00000;
        vOp[5] = 2'b11; vA[5] = 32'h40000000; vB[5] = 32'h40800000; vExp[5] = 32'h41000000;
        vOp[6] = 2'b00; vA[6] = 32'h3F000000; vB[6] = 32'h3F800000; vExp[6] = 32'h3FC00000;
        vOp[7] = 2'b01; vA[7] = 32'h40400000; vB[7] = 32'h40000000; vExp[7] = 32'h3F800000;

        // Reset behaviour, with both requesters valid during reset
        rst_n = 1'b0; resp_ready = 1'b1; latChk = 1'b0;
        drive0(1'b1, 2'b00, 32'h3F800000, 32'h3F800000, 32'h40000000);
        drive1(1'b1, 2'b00, 32'h3F800000, 32'h3F800000, 32'h40000000);
        @(negedge clk);
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        drive0(1'b0, 2'b00, '0, '0, '0);
        drive1(1'b0, 2'b00, '0, '0, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Contention: strict alternation starting with requester 0
        @(posedge clk); #1;
        drive0(1'b1, 2'b11, 32'h40000000, 32'h40400000, 32'h40C00000);
        drive1(1'b1, 2'b01, 32'h40400000, 32'h3F800000, 32'h40000000);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("cont_grant", 32'(req1_ready), 32'(i % 2));
            check("cont_any_ready", 32'(req0_ready | req1_ready), 32'd1);
        end
        @(posedge clk); #1;
        drive0(1'b0, 2'b00, '0, '0, '0);
        drive1(1'b0, 2'b00, '0, '0, '0);
        drain("cont");

        // Single add with latency check
        drive0(1'b1, 2'b00, 32'h3F800000, 32'h40000000, 32'h40400000);
        latChk = 1'b1;
        @(negedge clk);
        check("add_ready", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        drive0(1'b0, 2'b00, '0, '0, '0);
        latChk = 1'b0;
        check("add_alu_a", alu_a, 32'h3F800000);
        check("add_alu_b", alu_b, 32'h40000000);
        check("add_alu_op", 32'(alu_op), 32'd0);
        drain("add");

        // Backpressure: credit limit, then one pop frees exactly one issue
        resp_ready = 1'b0;
        drive0(1'b1, 2'b00, 32'h3F800000, 32'h40000000, 32'h40400000);
        acc = 0;
        repeat (10) begin
            @(negedge clk);
            acc += int'(req0_ready);
        end
        check("bp_accepts", 32'(acc), 32'd4);
        check("bp_ready_low", 32'(req0_ready), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        check("bp_resp_valid", 32'(resp_valid), 32'd1);
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_pop_cycle_ready", 32'(req0_ready), 32'd0);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        acc = 0;
        repeat (6) begin
            @(negedge clk);
            acc += int'(req0_ready);
        end
        check("bp_resume_accepts", 32'(acc), 32'd1);
        check("bp_sb_size", 32'(sb.size()), 32'd4);
        @(posedge clk); #1;
        drive0(1'b0, 2'b00, '0, '0, '0);
        resp_ready = 1'b1;
        drain("bp");

        // Back-to-back: eight ops from requester 1, responses on consecutive cycles
        for (int i = 0; i < 11; i++) begin
            if (i < 8) drive1(1'b1, vOp[i], vA[i], vB[i], vExp[i]);
            else       drive1(1'b0, 2'b00, '0, '0, '0);
            @(negedge clk);
            if (i < 8)  check("b2b_ready", 32'(req1_ready), 32'd1);
            if (i >= 3) check("b2b_resp_valid", 32'(resp_valid), 32'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("b2b_resp_done", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        drain("b2b");

        // Reset mid-flight, then tie goes to requester 0, then requester 1 streams alone
        drive0(1'b1, 2'b00, 32'h3F800000, 32'h40000000, 32'h40400000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        drive1(1'b1, 2'b11, 32'h40000000, 32'h40800000, 32'h41000000);
        @(negedge clk);
        check("mid_rst_req0_ready", 32'(req0_ready), 32'd0);
        check("mid_rst_req1_ready", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("post_rst_tie_req0", 32'(req0_ready), 32'd1);
        check("post_rst_tie_req1", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rr_req1_ready", 32'(req1_ready), 32'd1);
        check("rr_req0_ready", 32'(req0_ready), 32'd0);
        @(posedge clk); #1;
        drive0(1'b0, 2'b00, '0, '0, '0);
        repeat (4) begin
            @(negedge clk);
            check("solo_req1_ready", 32'(req1_ready), 32'd1);
        end
        @(posedge clk); #1;
        drive1(1'b0, 2'b00, '0, '0, '0);
        drain("solo");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
